pipeline_reg_if_id_skid: RTL and testbench

PIPELINE_REG_IF_ID_SKID -- requirements
Module: pipeline_reg_if_id_skid

---
 rtl/pipeline_reg_if_id_skid.sv | 114 +++++++++++
 tb/tb_pipeline_reg_if_id_skid.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_reg_if_id_skid.sv
// IF/ID pipeline register with a two-entry skid buffer and valid/ready flow.
// Optional downstream-stall counter: define IF_ID_STALL_CNT_EN.
module pipeline_reg_if_id_skid #(
  parameter int INST_W = 32,
  parameter int PC_W   = 32
`ifdef IF_ID_STALL_CNT_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [INST_W-1:0] inst_i,
  input  logic [PC_W-1:0]   pc_adder_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [PC_W-1:0]   pc_adder_o
`ifdef IF_ID_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t              state;
  logic [INST_W-1:0]   skid_inst;
  logic [PC_W-1:0]     skid_pc;
  logic                in_xfer;
  logic                out_xfer;

  assign in_xfer  = in_valid_i && in_ready_o;
  assign out_xfer = out_valid_o && out_ready_i;

  // Handshake flags are registered alongside the state they encode.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= EMPTY;
      out_valid_o <= 1'b0;
      in_ready_o  <= 1'b1;
      inst_o      <= '0;
      pc_adder_o  <= '0;
      skid_inst   <= '0;
      skid_pc     <= '0;
    end else if (flush_i) begin
      state       <= EMPTY;
      out_valid_o <= 1'b0;
      in_ready_o  <= 1'b1;
      inst_o      <= '0;
      pc_adder_o  <= '0;
      skid_inst   <= '0;
      skid_pc     <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            inst_o      <= inst_i;
            pc_adder_o  <= pc_adder_i;
            state       <= FULL;
            out_valid_o <= 1'b1;
            in_ready_o  <= 1'b1;
          end
        end
        FULL: begin
          if (in_xfer && out_xfer) begin
            inst_o     <= inst_i;
            pc_adder_o <= pc_adder_i;
          end else if (in_xfer) begin
            skid_inst  <= inst_i;
            skid_pc    <= pc_adder_i;
            state      <= SKID;
            in_ready_o <= 1'b0;
          end else if (out_xfer) begin
            state       <= EMPTY;
            out_valid_o <= 1'b0;
          end
        end
        SKID: begin
          if (out_xfer) begin
            inst_o     <= skid_inst;
            pc_adder_o <= skid_pc;
            state      <= FULL;
            in_ready_o <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          out_valid_o <= 1'b0;
          in_ready_o  <= 1'b1;
        end
      endcase
    end
  end

`ifdef IF_ID_STALL_CNT_EN
  // Saturating; flush deliberately leaves it alone.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (out_valid_o && !out_ready_i && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_reg_if_id_skid.sv
// Randomized and directed bench for pipeline_reg_if_id_skid.
// Reference model is a bounded FIFO queue of accepted entries.
module tb_pipeline_reg_if_id_skid;

  localparam int IW = 32;
  localparam int PW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [IW-1:0] inst_i;
  logic [PW-1:0] pc_adder_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [IW-1:0] inst_o;
  logic [PW-1:0] pc_adder_o;
`ifdef IF_ID_STALL_CNT_EN
  logic [CW-1:0] stall_cnt_o;
`endif

  int checks = 0;
  int failures = 0;

  logic [IW+PW-1:0] q[$];
  logic [IW+PW-1:0] last;
  int               exp_cnt;

  always #5 clk = ~clk;

`ifdef IF_ID_STALL_CNT_EN
  pipeline_reg_if_id_skid #(.INST_W(IW), .PC_W(PW), .CNT_W(CW)) dut (
`else
  pipeline_reg_if_id_skid #(.INST_W(IW), .PC_W(PW)) dut (
`endif
    .clk_i(clk),
    .rst_i(rst_i),
    .flush_i(flush_i),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .inst_i(inst_i),
    .pc_adder_i(pc_adder_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .inst_o(inst_o),
    .pc_adder_o(pc_adder_o)
`ifdef IF_ID_STALL_CNT_EN
    ,
    .stall_cnt_o(stall_cnt_o)
`endif
  );

  task automatic model_clear();
    q.delete();
    last = '0;
  endtask

  // Advance the model by one edge using the current inputs, then the DUT.
  task automatic tick();
    bit ox;
    bit ix;
    ox = (q.size() > 0) && out_ready_i;
    ix = in_valid_i && (q.size() < 2);
    if ((q.size() > 0) && !out_ready_i && exp_cnt < (1 << CW) - 1)
      exp_cnt++;
    if (flush_i) begin
      model_clear();
    end else begin
      if (ox) begin
        last = q[0];
        void'(q.pop_front());
      end
      if (ix) q.push_back({inst_i, pc_adder_i});
      if (q.size() > 0) last = q[0];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    inst_i = '0;
    pc_adder_i = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1'b1;
    model_clear();
    exp_cnt = 0;
    #2;
    checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 ||
        inst_o !== '0 || pc_adder_o !== '0) begin
      failures++;
      $display("FAIL reset got v=%b r=%b i=%h p=%h exp v=0 r=1 i=0 p=0",
               out_valid_o, in_ready_o, inst_o, pc_adder_o);
    end
`ifdef IF_ID_STALL_CNT_EN
    checks++;
    if (stall_cnt_o !== '0) begin
      failures++;
      $display("FAIL reset_cnt got=%0d exp=0", stall_cnt_o);
    end
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic test_streaming();
    out_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid_i = 1'b1;
      inst_i = 32'h11 + k;
      pc_adder_i = 32'h4 + 4 * k;
      tick();
      checks++;
      if (out_valid_o !== 1'b1 || in_ready_o !== 1'b1 ||
          inst_o !== 32'h11 + k || pc_adder_o !== 32'h4 + 4 * k) begin
        failures++;
        $display("FAIL stream%0d got v=%b r=%b i=%h p=%h exp v=1 r=1 i=%h p=%h",
                 k, out_valid_o, in_ready_o, inst_o, pc_adder_o,
                 32'h11 + k, 32'h4 + 4 * k);
      end
    end
    in_valid_i = 1'b0;
    tick();
    checks++;
    if (out_valid_o !== 1'b0 || inst_o !== 32'h15) begin
      failures++;
      $display("FAIL stream_drain got v=%b i=%h exp v=0 i=15",
               out_valid_o, inst_o);
    end
  endtask

  task automatic fill_skid();
    out_ready_i = 1'b0;
    in_valid_i = 1'b1;
    inst_i = 32'hA;
    pc_adder_i = 32'h100;
    tick();
    inst_i = 32'hB;
    pc_adder_i = 32'h104;
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic test_skid();
    fill_skid();
    checks++;
    if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0 ||
        inst_o !== 32'hA || pc_adder_o !== 32'h100) begin
      failures++;
      $display("FAIL skid_hold got v=%b r=%b i=%h p=%h exp v=1 r=0 i=a p=100",
               out_valid_o, in_ready_o, inst_o, pc_adder_o);
    end
    tick();
    checks++;
    if (inst_o !== 32'hA || in_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL skid_stall got i=%h r=%b exp i=a r=0", inst_o, in_ready_o);
    end
    out_ready_i = 1'b1;
    tick();
    checks++;
    if (out_valid_o !== 1'b1 || in_ready_o !== 1'b1 ||
        inst_o !== 32'hB || pc_adder_o !== 32'h104) begin
      failures++;
      $display("FAIL skid_second got v=%b r=%b i=%h p=%h exp v=1 r=1 i=b p=104",
               out_valid_o, in_ready_o, inst_o, pc_adder_o);
    end
    tick();
    checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL skid_empty got v=%b r=%b exp v=0 r=1",
               out_valid_o, in_ready_o);
    end
  endtask

  task automatic test_flush();
    fill_skid();
    flush_i = 1'b1;
    in_valid_i = 1'b1;
    inst_i = 32'hC;
    pc_adder_i = 32'h108;
    tick();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 ||
        inst_o !== '0 || pc_adder_o !== '0) begin
      failures++;
      $display("FAIL flush got v=%b r=%b i=%h p=%h exp v=0 r=1 i=0 p=0",
               out_valid_o, in_ready_o, inst_o, pc_adder_o);
    end
    out_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (out_valid_o !== 1'b0 || inst_o === 32'hC) begin
        failures++;
        $display("FAIL flush_leak%0d got v=%b i=%h exp v=0", k,
                 out_valid_o, inst_o);
      end
    end
  endtask

  task automatic test_async_reset();
    out_ready_i = 1'b0;
    in_valid_i = 1'b1;
    inst_i = 32'h55;
    pc_adder_i = 32'h200;
    tick();
    in_valid_i = 1'b0;
    #2;
    rst_i = 1'b1;
    model_clear();
    exp_cnt = 0;
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || inst_o !== '0 ||
        pc_adder_o !== '0 || in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL async_rst got v=%b i=%h p=%h r=%b exp v=0 i=0 p=0 r=1",
               out_valid_o, inst_o, pc_adder_o, in_ready_o);
    end
    @(negedge clk);
    rst_i = 1'b0;
    in_valid_i = 1'b1;
    inst_i = 32'h66;
    pc_adder_i = 32'h204;
    tick();
    in_valid_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b1 || inst_o !== 32'h66 || pc_adder_o !== 32'h204) begin
      failures++;
      $display("FAIL async_resume got v=%b i=%h p=%h exp v=1 i=66 p=204",
               out_valid_o, inst_o, pc_adder_o);
    end
    out_ready_i = 1'b1;
    tick();
  endtask

`ifdef IF_ID_STALL_CNT_EN
  task automatic test_stall_cnt();
    out_ready_i = 1'b0;
    in_valid_i = 1'b1;
    inst_i = 32'h77;
    pc_adder_i = 32'h300;
    tick();
    in_valid_i = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    checks++;
    if (stall_cnt_o !== 4'd15) begin
      failures++;
      $display("FAIL cnt_sat got=%0d exp=15", stall_cnt_o);
    end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    checks++;
    if (stall_cnt_o !== 4'd15) begin
      failures++;
      $display("FAIL cnt_flush got=%0d exp=15", stall_cnt_o);
    end
  endtask
`endif

  task automatic test_random();
    int shown;
    logic [IW+PW-1:0] exp_d;
    shown = 0;
    for (int n = 0; n < 10000; n++) begin
      in_valid_i = ($urandom_range(0, 9) < 7);
      out_ready_i = ($urandom_range(0, 9) < 6);
      flush_i = ($urandom_range(0, 199) == 0);
      inst_i = $urandom;
      pc_adder_i = $urandom;
      tick();
      exp_d = (q.size() > 0) ? q[0] : last;
      checks++;
      if (out_valid_o !== (q.size() > 0) || in_ready_o !== (q.size() < 2) ||
          {inst_o, pc_adder_o} !== exp_d) begin
        failures++;
        if (shown < 10)
          $display("FAIL rand@%0d got v=%b r=%b d=%h exp v=%b r=%b d=%h",
                   n, out_valid_o, in_ready_o, {inst_o, pc_adder_o},
                   q.size() > 0, q.size() < 2, exp_d);
        shown++;
      end
`ifdef IF_ID_STALL_CNT_EN
      checks++;
      if (stall_cnt_o !== CW'(exp_cnt)) begin
        failures++;
        if (shown < 10)
          $display("FAIL rand_cnt@%0d got=%0d exp=%0d", n, stall_cnt_o, exp_cnt);
        shown++;
      end
`endif
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_skid();
    test_flush();
    test_async_reset();
`ifdef IF_ID_STALL_CNT_EN
    test_stall_cnt();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
